nn_feature_loader: RTL and testbench
====================================

// Module: nn_feature_loader
// PURPOSE
//  Upstream stage of the NN Avalon slave. Consumes a keyword-ID token stream for one utterance.
//  Builds a 16-entry bag-of-words count vector and converts each count to IEEE-754 single.
//  Writes the 16 features to slave words 0..15 through an Avalon-MM master.
//  After settling, reads logits O_1/O_2 from words 16/17 and presents the winning intent with a valid pulse.
// PARAMETERS
//  N_FEAT      16  feature words written (slave addr 0..N_FEAT-1)
//  CNT_W       8   per-feature counter width; counts saturate at 2**CNT_W-1
//  SETTLE_CYC  4   idle cycles after last write before first read (NN combinational settle)
//  RD_LAT      1   cycles from read acceptance to M_READDATA valid
// PORTS
//  CLK            in   1   clock
//  RESET_N        in   1   async active-low reset
//  TOK_VALID      in   1   token valid
//  TOK_READY      out  1   token accepted when VALID&READY
//  TOK_ID         in   5   keyword index; >=N_FEAT is out-of-vocabulary (ignored, still accepted)
//  TOK_LAST       in   1   final token of utterance
//  M_ADDR         out  5   master word address
//  M_WRITE        out  1   write request
//  M_READ         out  1   read request
//  M_BYTE_EN      out  4   always 4'hF
//  M_WRITEDATA    out  32  feature float
//  M_READDATA     in   32  slave read data
//  M_WAITREQUEST  in   1   slave stall; request held stable while high
//  RES_VALID      out  1   one-cycle pulse, result fields valid
//  RES_O1/RES_O2  out  32  logits read from words 16/17
//  RES_CLASS      out  1   0 if O_1 > O_2 (float compare, +0 == -0), else 1
//  BUSY           out  1   high in every state except IDLE/ACCUM
// BEHAVIOUR
//  - Reset: state IDLE; all counts 0; TOK_READY=1; M_WRITE=M_READ=0; M_ADDR=0;
//    M_WRITEDATA=0; RES_*=0; BUSY=0.
//  - IDLE/ACCUM: TOK_READY=1.
//    Accepted token with ID<N_FEAT: count[ID]++ (saturating).
//    First accepted token moves IDLE->ACCUM. Accepted TOK_LAST -> WRITE; that token is counted first.
//  - WRITE: TOK_READY=0. Issues N_FEAT writes, addr 0..N_FEAT-1 in order, one per cycle when waitrequest is low.
//    M_WRITE/M_ADDR/M_WRITEDATA are held while M_WAITREQUEST=1.
//    The write at addr N_FEAT-1 is accepted -> SETTLE.
//  - SETTLE: no requests for exactly SETTLE_CYC cycles -> RD_O1.
//  - RD_O1: read addr 16; capture data RD_LAT cycles after acceptance -> RD_O2.
//  - RD_O2: same, addr 17 -> DONE.
//  - DONE: one cycle. RES_VALID=1, RES_O1/O2/CLASS updated. All counts cleared.
//    Then IDLE; RES_O1/O2/CLASS hold until the next DONE.
//  - Int->float: 0 -> 32'h0000_0000. n>0 -> exponent 127+msb(n), mantissa = n left-justified, no rounding needed.
//  - Empty utterance (TOK_LAST only, or only OOV tokens): all-zero features still written, full sequence runs.
//  - Outside IDLE/ACCUM no token is accepted. TOK_VALID is ignored; upstream must hold the token.
//  - RESET_N asserted mid-transaction: master requests drop immediately, counts lost.
//    No partial result is emitted.
// CONFIGURATION
//  NN_BINARY_FEAT_EN
//  - defined: each feature is presence only. Written value is 32'h3F80_0000 (1.0) if count>0, else 0.
//  - undefined: written value is float(count).
//  - All timing is identical in both builds.
// STRUCTURE
//  Package nn_loader_pkg:
//  - state enum {IDLE,ACCUM,WRITE,SETTLE,RD_O1,RD_O2,DONE}
//  - O1_ADDR=5'd16, O2_ADDR=5'd17
//  - FLOAT_ONE=32'h3F80_0000
//  - float_gt function shared with the comparator logic
//  Sub-module nn_uint_to_float: combinational CNT_W-bit unsigned -> IEEE-754 single (priority encoder + shift).
// TESTING
//  1. TOK_IDs 3,3,7 (LAST on 7), no waitrequest:
//     writes addr3=32'h4000_0000, addr7=32'h3F80_0000, others 0. Then addr 16/17 reads.
//     Model O1=32'h3F00_0000 (0.5), O2=32'hBF00_0000 (-0.5) -> RES_CLASS=0, one RES_VALID pulse.
//  2. 300 tokens of ID 5 with CNT_W=8 -> addr5 written 32'h437F_0000 (255.0, saturated).
//     With NN_BINARY_FEAT_EN -> 32'h3F80_0000.
//  3. Single TOK_LAST with ID 20 (OOV) -> 16 zero writes, full read sequence, RES_VALID once.
//  4. Random M_WAITREQUEST (50%) during writes and reads:
//     each address written exactly once and in order, request signals stable while stalled,
//     results unchanged vs test 1.
//  5. Deassert RESET_N during WRITE at addr 9 -> outputs return to reset values asynchronously.
//     A following utterance ID 1 (LAST) writes only addr1=1.0 (no stale counts).
//  6. TOK_VALID held high through BUSY -> TOK_READY=0, no count change.
//     Tie case O1=32'h8000_0000, O2=32'h0000_0000 -> RES_CLASS=1.

Source files
------------

// File: rtl/nn_feature_loader_pkg.sv
// Shared types and helpers for the NN feature loader.
// Holds the FSM state encoding, logit addresses and the float compare.
package nn_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        WRITE,
        SETTLE,
        RD_O1,
        RD_O2,
        DONE
    } state_t;

    localparam logic [4:0]  O1_ADDR   = 5'd16;
    localparam logic [4:0]  O2_ADDR   = 5'd17;
    localparam logic [31:0] FLOAT_ONE = 32'h3F80_0000;

    // Ordered compare of two singles; +0 and -0 compare equal.
    function automatic logic float_gt(
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic res;
        if (a[30:0] == '0 && b[30:0] == '0)
            res = 1'b0;
        else if (a[31] != b[31])
            res = b[31];
        else if (!a[31])
            res = a[30:0] > b[30:0];
        else
            res = a[30:0] < b[30:0];
        return res;
    endfunction

endpackage

// File: rtl/nn_feature_loader_if.sv
// Avalon-MM word bus between the feature loader and the NN slave.
// The loader drives the master modport.
interface nn_feature_loader_if;

    logic [4:0]  M_ADDR;
    logic        M_WRITE;
    logic        M_READ;
    logic [3:0]  M_BYTE_EN;
    logic [31:0] M_WRITEDATA;
    logic [31:0] M_READDATA;
    logic        M_WAITREQUEST;

    modport master (
        output M_ADDR,
        output M_WRITE,
        output M_READ,
        output M_BYTE_EN,
        output M_WRITEDATA,
        input  M_READDATA,
        input  M_WAITREQUEST
    );

    modport slave (
        input  M_ADDR,
        input  M_WRITE,
        input  M_READ,
        input  M_BYTE_EN,
        input  M_WRITEDATA,
        output M_READDATA,
        output M_WAITREQUEST
    );

endinterface

// File: rtl/nn_feature_loader_cvt.sv
// Combinational unsigned count to IEEE-754 single conversion.
// Exact for W <= 24, so no rounding stage is needed.
module nn_uint_to_float #(
    parameter int W = 8
) (
    input  logic [W-1:0] n,
    output logic [31:0]  f
);

    localparam int MW = $clog2(W);

    logic [MW-1:0] msb;
    logic [22:0]   mant;

    always_comb begin
        msb = '0;
        for (int i = 0; i < W; i++)
            if (n[i])
                msb = i[MW-1:0];
        // Hidden bit shifts out past bit 22.
        mant = 23'(n) << (5'd23 - 5'(msb));
        f = '0;
        if (|n)
            f = {1'b0, 8'd127 + 8'(msb), mant};
    end

endmodule

// File: rtl/nn_feature_loader.sv
// Bag-of-words feature loader: counts tokens, writes floats, reads logits.
// Define NN_BINARY_FEAT_EN for presence-only (0.0/1.0) features.
module nn_feature_loader
    import nn_loader_pkg::*;
#(
    parameter int N_FEAT     = 16,
    parameter int CNT_W      = 8,
    parameter int SETTLE_CYC = 4,
    parameter int RD_LAT     = 1
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         TOK_VALID,
    output logic         TOK_READY,
    input  logic [4:0]   TOK_ID,
    input  logic         TOK_LAST,
    nn_feature_loader_if.master m,
    output logic         RES_VALID,
    output logic [31:0]  RES_O1,
    output logic [31:0]  RES_O2,
    output logic         RES_CLASS,
    output logic         BUSY
);

    localparam int IW = $clog2(N_FEAT);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int LW = $clog2(RD_LAT + 1);

    state_t state, state_n;

    logic [CNT_W-1:0] cnt [N_FEAT];
    logic [IW-1:0]    widx;
    logic [SW-1:0]    scnt;
    logic [LW-1:0]    lat;
    logic             rd_pend;
    logic [31:0]      o1_q;

    logic        tok_acc;
    logic        wr_acc;
    logic        rd_acc;
    logic        rd_cap;
    logic [31:0] feat;

    logic [CNT_W-1:0] cur_cnt;
    assign cur_cnt = cnt[widx];

`ifdef NN_BINARY_FEAT_EN
    assign feat = (|cur_cnt) ? FLOAT_ONE : 32'h0;
`else
    nn_uint_to_float #(.W(CNT_W)) u_cvt (
        .n (cur_cnt),
        .f (feat)
    );
`endif

    assign m.M_BYTE_EN = 4'hF;

    always_comb begin
        state_n       = state;
        TOK_READY     = 1'b0;
        BUSY          = 1'b1;
        RES_VALID     = 1'b0;
        m.M_WRITE     = 1'b0;
        m.M_READ      = 1'b0;
        m.M_ADDR      = '0;
        m.M_WRITEDATA = '0;
        tok_acc       = 1'b0;
        wr_acc        = 1'b0;
        rd_acc        = 1'b0;
        rd_cap        = 1'b0;
        unique case (state)
            IDLE, ACCUM: begin
                BUSY      = 1'b0;
                TOK_READY = 1'b1;
                tok_acc   = TOK_VALID;
                if (tok_acc)
                    state_n = TOK_LAST ? WRITE : ACCUM;
            end
            WRITE: begin
                m.M_WRITE     = 1'b1;
                m.M_ADDR      = 5'(widx);
                m.M_WRITEDATA = feat;
                wr_acc        = !m.M_WAITREQUEST;
                if (wr_acc && widx == IW'(N_FEAT - 1))
                    state_n = SETTLE;
            end
            SETTLE: begin
                if (scnt == SW'(SETTLE_CYC - 1))
                    state_n = RD_O1;
            end
            RD_O1, RD_O2: begin
                m.M_ADDR = (state == RD_O1) ? O1_ADDR : O2_ADDR;
                m.M_READ = !rd_pend;
                rd_acc   = !rd_pend && !m.M_WAITREQUEST;
                rd_cap   = rd_pend && lat == LW'(RD_LAT - 1);
                if (rd_cap)
                    state_n = (state == RD_O1) ? RD_O2 : DONE;
            end
            DONE: begin
                RES_VALID = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            cnt       <= '{default: '0};
            widx      <= '0;
            scnt      <= '0;
            lat       <= '0;
            rd_pend   <= 1'b0;
            o1_q      <= '0;
            RES_O1    <= '0;
            RES_O2    <= '0;
            RES_CLASS <= 1'b0;
        end else begin
            state <= state_n;
            if (tok_acc && TOK_ID < 5'(N_FEAT)
                && cnt[TOK_ID[IW-1:0]] != '1)
                cnt[TOK_ID[IW-1:0]] <= cnt[TOK_ID[IW-1:0]] + 1'b1;
            if (state == DONE)
                cnt <= '{default: '0};
            if (wr_acc)
                widx <= (widx == IW'(N_FEAT - 1)) ? '0 : widx + 1'b1;
            scnt <= (state == SETTLE) ? scnt + 1'b1 : '0;
            if (rd_acc) begin
                rd_pend <= 1'b1;
                lat     <= '0;
            end else if (rd_cap) begin
                rd_pend <= 1'b0;
            end else if (rd_pend) begin
                lat <= lat + 1'b1;
            end
            if (rd_cap && state == RD_O1)
                o1_q <= m.M_READDATA;
            // Result fields only move on the DONE edge.
            if (rd_cap && state == RD_O2) begin
                RES_O1    <= o1_q;
                RES_O2    <= m.M_READDATA;
                RES_CLASS <= !float_gt(o1_q, m.M_READDATA);
            end
        end
    end

endmodule

// File: tb/tb_nn_feature_loader.sv
// Scoreboard bench for nn_feature_loader with a modelled Avalon slave.
// Works in both NN_BINARY_FEAT_EN builds.
module tb_nn_feature_loader;
    import nn_loader_pkg::*;

    localparam int SETTLE = 4;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [31:0] o1;
        logic [31:0] o2;
        logic        cls;
    } res_t;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        TOK_VALID = 1'b0;
    logic        TOK_READY;
    logic [4:0]  TOK_ID = '0;
    logic        TOK_LAST = 1'b0;
    logic        RES_VALID;
    logic [31:0] RES_O1;
    logic [31:0] RES_O2;
    logic        RES_CLASS;
    logic        BUSY;

    nn_feature_loader_if bus();

    nn_feature_loader dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .TOK_VALID (TOK_VALID),
        .TOK_READY (TOK_READY),
        .TOK_ID    (TOK_ID),
        .TOK_LAST  (TOK_LAST),
        .m         (bus),
        .RES_VALID (RES_VALID),
        .RES_O1    (RES_O1),
        .RES_O2    (RES_O2),
        .RES_CLASS (RES_CLASS),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    int   checks = 0;
    int   errors = 0;
    int   res_cnt = 0;
    int   mcnt [16];
    logic rand_wait = 1'b0;
    logic [31:0] o1_val = 32'h3F00_0000;
    logic [31:0] o2_val = 32'hBF00_0000;

    wr_t        wq [$];
    logic [4:0] rq [$];
    res_t       resq [$];

    function automatic logic [31:0] tb_feat(input int n);
        int e;
`ifdef NN_BINARY_FEAT_EN
        e = 0;
        return (n > 0) ? 32'h3F80_0000 : 32'h0;
`else
        if (n == 0)
            return 32'h0;
        e = 0;
        while ((n >> (e + 1)) != 0)
            e++;
        return {1'b0, 8'(127 + e), 23'((n - (1 << e)) << (23 - e))};
`endif
    endfunction

    // Slave model and scoreboard monitor.
    logic        rd_pend = 1'b0;
    logic [31:0] rd_data = '0;
    logic        st_hold = 1'b0;
    logic        h_we, h_re;
    logic [4:0]  h_addr;
    logic [31:0] h_data;
    logic        gap_armed = 1'b0;
    int          cyc = 0;
    int          wr_last_cyc = 0;
    wr_t         ew;
    logic [4:0]  ea;
    res_t        er;

    always @(negedge CLK) begin
        if (!RESET_N) begin
            bus.M_WAITREQUEST = 1'b0;
            bus.M_READDATA    = 32'hDEAD_BEEF;
            rd_pend   = 1'b0;
            st_hold   = 1'b0;
            gap_armed = 1'b0;
        end else begin
            cyc++;
            bus.M_READDATA = rd_pend ? rd_data : 32'hDEAD_BEEF;
            rd_pend = 1'b0;
            if (st_hold) begin
                checks++;
                if (bus.M_WRITE !== h_we || bus.M_READ !== h_re
                    || bus.M_ADDR !== h_addr
                    || (h_we && bus.M_WRITEDATA !== h_data)) begin
                    errors++;
                    $display("FAIL stall_hold got w%0b r%0b a%0d d%h want w%0b r%0b a%0d d%h",
                        bus.M_WRITE, bus.M_READ, bus.M_ADDR,
                        bus.M_WRITEDATA, h_we, h_re, h_addr, h_data);
                end
            end
            bus.M_WAITREQUEST = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
            st_hold = (bus.M_WRITE || bus.M_READ) && bus.M_WAITREQUEST;
            h_we   = bus.M_WRITE;
            h_re   = bus.M_READ;
            h_addr = bus.M_ADDR;
            h_data = bus.M_WRITEDATA;
            if (bus.M_READ && gap_armed) begin
                checks++;
                gap_armed = 1'b0;
                if (cyc - wr_last_cyc != SETTLE + 1) begin
                    errors++;
                    $display("FAIL settle_gap got %0d want %0d",
                        cyc - wr_last_cyc, SETTLE + 1);
                end
            end
            if (bus.M_WRITE && !bus.M_WAITREQUEST) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL extra_write got a%0d d%h want none",
                        bus.M_ADDR, bus.M_WRITEDATA);
                end else begin
                    ew = wq.pop_front();
                    if (bus.M_ADDR !== ew.addr
                        || bus.M_WRITEDATA !== ew.data) begin
                        errors++;
                        $display("FAIL write got a%0d d%h want a%0d d%h",
                            bus.M_ADDR, bus.M_WRITEDATA, ew.addr, ew.data);
                    end
                end
                if (bus.M_ADDR == 5'd15) begin
                    gap_armed   = 1'b1;
                    wr_last_cyc = cyc;
                end
            end
            if (bus.M_READ && !bus.M_WAITREQUEST) begin
                checks++;
                ea = (rq.size() != 0) ? rq.pop_front() : 5'd31;
                if (bus.M_ADDR !== ea) begin
                    errors++;
                    $display("FAIL read_addr got %0d want %0d",
                        bus.M_ADDR, ea);
                end
                rd_pend = 1'b1;
                rd_data = (bus.M_ADDR == 5'd16) ? o1_val
                        : (bus.M_ADDR == 5'd17) ? o2_val
                        : 32'hBAD0_0000;
            end
            if (RES_VALID) begin
                res_cnt++;
                checks++;
                if (resq.size() == 0) begin
                    errors++;
                    $display("FAIL extra_result got o1 %h want none", RES_O1);
                end else begin
                    er = resq.pop_front();
                    if (RES_O1 !== er.o1 || RES_O2 !== er.o2
                        || RES_CLASS !== er.cls) begin
                        errors++;
                        $display("FAIL result got %h %h %0b want %h %h %0b",
                            RES_O1, RES_O2, RES_CLASS,
                            er.o1, er.o2, er.cls);
                    end
                end
            end
            if (BUSY && TOK_VALID) begin
                checks++;
                if (TOK_READY !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_ready got %0b want 0", TOK_READY);
                end
            end
        end
    end

    task automatic model_tok(input int id);
        if (id < 16 && mcnt[id] < 255)
            mcnt[id]++;
    endtask

    task automatic push_expect(input logic cls);
        for (int a = 0; a < 16; a++) begin
            wq.push_back('{addr: 5'(a), data: tb_feat(mcnt[a])});
            mcnt[a] = 0;
        end
        rq.push_back(5'd16);
        rq.push_back(5'd17);
        resq.push_back('{o1: o1_val, o2: o2_val, cls: cls});
    endtask

    // Called at posedge+1; returns at posedge+1 after acceptance.
    task automatic send_tok(input logic [4:0] id, input logic last);
        int n;
        TOK_VALID = 1'b1;
        TOK_ID    = id;
        TOK_LAST  = last;
        n = 0;
        while (TOK_READY !== 1'b1 && n < 500) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL tok_timeout got ready %0b want 1", TOK_READY);
        end
        @(posedge CLK);
        #1;
        TOK_VALID = 1'b0;
        TOK_LAST  = 1'b0;
    endtask

    task automatic wait_res(input int target);
        int n;
        n = 0;
        while (res_cnt < target && n < 2000) begin
            @(posedge CLK);
            n++;
        end
        checks++;
        if (res_cnt < target) begin
            errors++;
            $display("FAIL res_timeout got %0d want %0d", res_cnt, target);
        end
        repeat (8) @(posedge CLK);
        #1;
        checks++;
        if (res_cnt != target || wq.size() != 0
            || rq.size() != 0 || resq.size() != 0) begin
            errors++;
            $display("FAIL leftover got res %0d w %0d r %0d q %0d want %0d 0 0 0",
                res_cnt, wq.size(), rq.size(), resq.size(), target);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (TOK_READY !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL rst_tok got rdy %0b busy %0b want 1 0",
                TOK_READY, BUSY);
        end
        checks++;
        if (bus.M_WRITE !== 1'b0 || bus.M_READ !== 1'b0
            || bus.M_ADDR !== 5'd0 || bus.M_WRITEDATA !== 32'h0) begin
            errors++;
            $display("FAIL rst_bus got w%0b r%0b a%0d d%h want 0 0 0 0",
                bus.M_WRITE, bus.M_READ, bus.M_ADDR, bus.M_WRITEDATA);
        end
        checks++;
        if (RES_VALID !== 1'b0 || RES_O1 !== 32'h0
            || RES_O2 !== 32'h0 || RES_CLASS !== 1'b0) begin
            errors++;
            $display("FAIL rst_res got %0b %h %h %0b want 0 0 0 0",
                RES_VALID, RES_O1, RES_O2, RES_CLASS);
        end
        checks++;
        if (bus.M_BYTE_EN !== 4'hF) begin
            errors++;
            $display("FAIL byte_en got %h want f", bus.M_BYTE_EN);
        end
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_basic;
        int base;
        base = res_cnt;
        model_tok(3);
        send_tok(5'd3, 1'b0);
        model_tok(3);
        send_tok(5'd3, 1'b0);
        model_tok(7);
        push_expect(1'b0);
        send_tok(5'd7, 1'b1);
        wait_res(base + 1);
        checks++;
        if (RES_O1 !== 32'h3F00_0000 || RES_CLASS !== 1'b0) begin
            errors++;
            $display("FAIL res_hold got %h %0b want 3f000000 0",
                RES_O1, RES_CLASS);
        end
    endtask

    task automatic test_saturate;
        int base;
        base = res_cnt;
        for (int i = 0; i < 299; i++) begin
            model_tok(5);
            send_tok(5'd5, 1'b0);
        end
        model_tok(5);
        push_expect(1'b0);
        send_tok(5'd5, 1'b1);
        wait_res(base + 1);
    endtask

    task automatic test_oov;
        int base;
        base = res_cnt;
        model_tok(20);
        push_expect(1'b0);
        send_tok(5'd20, 1'b1);
        wait_res(base + 1);
    endtask

    task automatic test_waitreq;
        int base;
        base = res_cnt;
        rand_wait = 1'b1;
        model_tok(3);
        send_tok(5'd3, 1'b0);
        model_tok(3);
        send_tok(5'd3, 1'b0);
        model_tok(7);
        push_expect(1'b0);
        send_tok(5'd7, 1'b1);
        wait_res(base + 1);
        rand_wait = 1'b0;
    endtask

    task automatic test_reset_mid;
        int base;
        int n;
        base = res_cnt;
        model_tok(4);
        send_tok(5'd4, 1'b0);
        model_tok(4);
        send_tok(5'd4, 1'b0);
        model_tok(9);
        push_expect(1'b0);
        send_tok(5'd9, 1'b1);
        n = 0;
        while (!(bus.M_WRITE === 1'b1 && bus.M_ADDR === 5'd9)
               && n < 200) begin
            @(posedge CLK);
            #1;
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL addr9_timeout got a%0d want 9", bus.M_ADDR);
        end
        #2;
        RESET_N = 1'b0;
        #1;
        checks++;
        if (bus.M_WRITE !== 1'b0 || bus.M_ADDR !== 5'd0
            || BUSY !== 1'b0 || TOK_READY !== 1'b1) begin
            errors++;
            $display("FAIL async_rst got w%0b a%0d busy%0b rdy%0b want 0 0 0 1",
                bus.M_WRITE, bus.M_ADDR, BUSY, TOK_READY);
        end
        checks++;
        if (RES_O1 !== 32'h0 || RES_O2 !== 32'h0) begin
            errors++;
            $display("FAIL async_res got %h %h want 0 0", RES_O1, RES_O2);
        end
        wq.delete();
        rq.delete();
        resq.delete();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if (res_cnt != base) begin
            errors++;
            $display("FAIL partial_res got %0d want %0d", res_cnt, base);
        end
        model_tok(1);
        push_expect(1'b0);
        send_tok(5'd1, 1'b1);
        wait_res(base + 1);
    endtask

    task automatic test_busy_hold;
        int base;
        base = res_cnt;
        o1_val = 32'h8000_0000;
        o2_val = 32'h0000_0000;
        model_tok(2);
        push_expect(1'b1);
        send_tok(5'd2, 1'b1);
        TOK_VALID = 1'b1;
        TOK_ID    = 5'd3;
        TOK_LAST  = 1'b1;
        #1;
        checks++;
        if (TOK_READY !== 1'b0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL hold_ready got rdy%0b busy%0b want 0 1",
                TOK_READY, BUSY);
        end
        model_tok(3);
        push_expect(1'b1);
        send_tok(5'd3, 1'b1);
        wait_res(base + 2);
        checks++;
        if (RES_CLASS !== 1'b1) begin
            errors++;
            $display("FAIL tie_class got %0b want 1", RES_CLASS);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++)
            mcnt[i] = 0;
        test_reset;
        test_basic;
        test_saturate;
        test_oov;
        test_waitreq;
        test_reset_mid;
        test_busy_hold;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
